// File: rtl/l2_spandex_out_queue.sv
// -----------------------------------------------------------------------------
// l2_spandex_out_queue
//
// Output staging between the L2 core's outgoing coherence channels and the
// NoC. Each of NUM_CH channels (default: rsp_out, fwd_out, req_out, in that
// priority order) owns a DEPTH-entry FIFO. The FIFO heads are merged onto one
// output port by fixed-priority or round-robin arbitration. Once presented,
// a grant is held until it is accepted. Per-channel occupancy and a global
// empty flag let flush/fence logic wait for the queues to drain.
//
// Handshake rule (both sides): a transfer happens at a rising edge where
// valid && ready are both high. A source that raises valid keeps valid and
// its payload stable until that transfer. in_ready never depends on
// out_ready, and out_valid/out_data/out_ch never depend on out_ready.
//
// Ports
//   clk        in   1              clock, rising edge
//   rst        in   1              synchronous active-high reset
//   in_valid   in   NUM_CH         per-channel message valid
//   in_ready   out  NUM_CH         per-channel accept (FIFO not full, rst low)
//   in_data    in   NUM_CH*MSG_W   channel c at [c*MSG_W +: MSG_W]
//   out_valid  out  1              merged output valid
//   out_ready  in   1              downstream accept
//   out_data   out  MSG_W          head of granted FIFO, 0 when idle
//   out_ch     out  CH_W           granted channel index, 0 when idle
//   occupancy  out  NUM_CH*CNT_W   registered entry count per channel
//   empty      out  1              all FIFOs empty
// -----------------------------------------------------------------------------
module l2_spandex_out_queue #(
    parameter int NUM_CH   = 3,
    parameter int MSG_W    = 64,
    parameter int DEPTH    = 4,
    parameter int ARB_MODE = 0,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         in_valid,
    output logic [NUM_CH-1:0]         in_ready,
    input  logic [NUM_CH*MSG_W-1:0]   in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [MSG_W-1:0]          out_data,
    output logic [CH_W-1:0]           out_ch,
    output logic [NUM_CH*CNT_W-1:0]   occupancy,
    output logic                      empty
);

    localparam int                PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // FIFO storage and bookkeeping
    logic [MSG_W-1:0] mem    [NUM_CH][DEPTH];
    logic [PTR_W-1:0] wr_ptr [NUM_CH];
    logic [PTR_W-1:0] rd_ptr [NUM_CH];
    logic [CNT_W-1:0] count  [NUM_CH];

    logic [NUM_CH-1:0] nonempty;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;

    // Arbiter state
    arb_state_t       arb_state;
    arb_state_t       arb_state_next;
    logic [CH_W-1:0]  grant_q;
    logic [CH_W-1:0]  grant_next;
    logic [CH_W-1:0]  rr_ptr;
    logic [CH_W-1:0]  rr_ptr_next;

    logic [CH_W-1:0]  pick;
    logic             pick_valid;
    logic [CH_W-1:0]  sel;
    logic             handshake;

    // Candidate channel examined at search step 'offset'. Round-robin starts
    // at rr_ptr and wraps; fixed priority simply walks from index 0.
    function automatic int cand(input logic [CH_W-1:0] base, input int offset);
        if (ARB_MODE == 1) begin
            return (int'(base) + offset) % NUM_CH;
        end
        return offset;
    endfunction

    // -------------------------------------------------------------------------
    // Per-channel status. in_ready uses registered count only, so a pop in the
    // same cycle cannot re-open a full FIFO until the next edge.
    // -------------------------------------------------------------------------
    always_comb begin
        nonempty  = '0;
        in_ready  = '0;
        push      = '0;
        occupancy = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            nonempty[c]                   = (count[c] != '0);
            in_ready[c]                   = !rst && (count[c] != FULL_CNT);
            push[c]                       = in_valid[c] && in_ready[c];
            occupancy[c*CNT_W +: CNT_W]   = count[c];
        end
        empty = (nonempty == '0);
    end

    // -------------------------------------------------------------------------
    // Arbitration among non-empty FIFOs (used only while no grant is held)
    // -------------------------------------------------------------------------
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!pick_valid && nonempty[cand(rr_ptr, i)]) begin
                pick       = CH_W'(cand(rr_ptr, i));
                pick_valid = 1'b1;
            end
        end
    end

    // A held grant always wins over a fresh pick, so a higher-priority arrival
    // cannot preempt a message already being presented.
    assign sel       = (arb_state == ARB_LOCKED) ? grant_q : pick;
    assign handshake = out_valid && out_ready;

    always_comb begin
        pop = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            pop[c] = handshake && (sel == CH_W'(c));
        end
    end

    // -------------------------------------------------------------------------
    // Arbiter FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            arb_state <= ARB_IDLE;
            grant_q   <= '0;
            rr_ptr    <= '0;
        end else begin
            arb_state <= arb_state_next;
            grant_q   <= grant_next;
            rr_ptr    <= rr_ptr_next;
        end
    end

    // -------------------------------------------------------------------------
    // Arbiter FSM: next state. A presented-but-unaccepted message locks the
    // grant; an accepted one returns to IDLE so the next cycle re-arbitrates
    // with no bubble.
    // -------------------------------------------------------------------------
    always_comb begin
        arb_state_next = arb_state;
        grant_next     = grant_q;
        rr_ptr_next    = rr_ptr;
        if (handshake) begin
            arb_state_next = ARB_IDLE;
            if (ARB_MODE == 1) begin
                rr_ptr_next = CH_W'((int'(sel) + 1) % NUM_CH);
            end
        end else if (out_valid) begin
            arb_state_next = ARB_LOCKED;
            grant_next     = sel;
        end
    end

    // -------------------------------------------------------------------------
    // Arbiter FSM: outputs (registered state and rst only)
    // -------------------------------------------------------------------------
    always_comb begin
        out_valid = !rst && ((arb_state == ARB_LOCKED) || pick_valid);
        out_ch    = '0;
        out_data  = '0;
        if (out_valid) begin
            out_ch   = sel;
            out_data = mem[sel][rd_ptr[sel]];
        end
    end

    // -------------------------------------------------------------------------
    // FIFO pointers and counts. Pointers wrap naturally; count alone decides
    // full and empty.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (rst) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                count[c]  <= '0;
            end else begin
                if (push[c]) begin
                    wr_ptr[c] <= wr_ptr[c] + PTR_W'(1);
                end
                if (pop[c]) begin
                    rd_ptr[c] <= rd_ptr[c] + PTR_W'(1);
                end
                if (push[c] && !pop[c]) begin
                    count[c] <= count[c] + CNT_W'(1);
                end else if (!push[c] && pop[c]) begin
                    count[c] <= count[c] - CNT_W'(1);
                end
            end
        end
    end

    // FIFO storage is intentionally not reset; count gates what is visible.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (push[c]) begin
                mem[c][wr_ptr[c]] <= in_data[c*MSG_W +: MSG_W];
            end
        end
    end

endmodule
